// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the LEGv8 multi-cycle stage sequencer: state codes,
// decoded opcode constants/masks and the wait-timer width.
package stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALTED    = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } op_class_e;

  localparam int WORD     = 64;
  localparam int OPCODE_W = 11;
  localparam int WAIT_W   = 8;

  // Opcodes are compared in the 11-bit field at the top of the instruction.
  localparam logic [OPCODE_W-1:0] OP_LDUR     = 11'b11111000010;
  localparam logic [OPCODE_W-1:0] OP_STUR     = 11'b11111000000;
  localparam logic [OPCODE_W-1:0] OP_B        = 11'b00010100000;
  localparam logic [OPCODE_W-1:0] OP_B_MASK   = 11'b11111100000;
  localparam logic [OPCODE_W-1:0] OP_CBZ      = 11'b10110100000;
  localparam logic [OPCODE_W-1:0] OP_CBZ_MASK = 11'b11111111000;

endpackage

// File: rtl/stage_sequencer_if.sv
// Control bundle between the stage sequencer (master) and the datapath and
// memories it steers (slave).
interface stage_sequencer_if #(
  parameter int INSTR_LEN = 32,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic                 halt_req;
  logic [INSTR_LEN-1:0] instruction;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 ir_write;
  logic                 reg_read_en;
  logic                 alu_en;
  logic                 dmem_req;
  logic                 reg_write_en;
  logic                 pc_write;
  logic [2:0]           stage;
  logic                 busy;
  logic                 err;
  logic [CNT_W-1:0]     instr_count;

  modport master (
    input  start, halt_req, instruction, imem_ready, dmem_ready,
    output imem_req, ir_write, reg_read_en, alu_en, dmem_req, reg_write_en,
           pc_write, stage, busy, err, instr_count
  );

  modport slave (
    output start, halt_req, instruction, imem_ready, dmem_ready,
    input  imem_req, ir_write, reg_read_en, alu_en, dmem_req, reg_write_en,
           pc_write, stage, busy, err, instr_count
  );
endinterface

// File: rtl/stage_sequencer_wait_timer.sv
// Memory wait counter: counts cycles while a request is outstanding and flags
// when the count has reached the configured timeout.
module wait_timer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  logic [WAIT_W-1:0] count_q;

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + WAIT_W'(1);
    end
  end

  assign tc = (count_q == WAIT_W'(LIMIT));

endmodule

// File: rtl/stage_sequencer.sv
// Single-clock multi-cycle sequencer stepping each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with handshakes, halt and error.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int INSTR_LEN   = 32,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter bit SKIP_EN     = 1'b1
) (
  input logic                clk,
  input logic                reset,
  stage_sequencer_if.master  bus
);

  state_e          state_q, state_d;
  op_class_e       op_class;
  logic            ir_write, retire;
  logic            in_wait, ready_sel, wait_inc, wait_tc;
  logic [CNT_W-1:0] count_q;
  logic            unused_instr_bits;

  function automatic op_class_e classify(input logic [OPCODE_W-1:0] op);
    if (op == OP_LDUR) return CLS_LOAD;
    if (op == OP_STUR) return CLS_STORE;
    if ((op & OP_B_MASK) == OP_B || (op & OP_CBZ_MASK) == OP_CBZ) return CLS_BRANCH;
    return CLS_ALU;
  endfunction

  assign op_class          = classify(bus.instruction[INSTR_LEN-1 -: OPCODE_W]);
  assign unused_instr_bits = ^bus.instruction[INSTR_LEN-OPCODE_W-1:0];

  // The timer only runs while a request is pending; any other cycle is an entry point.
  assign in_wait   = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
  assign ready_sel = (state_q == ST_FETCH) ? bus.imem_ready : bus.dmem_ready;
  assign wait_inc  = in_wait && !ready_sel;

  wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait_timer (
    .clk   (clk),
    .reset (reset),
    .clear (!wait_inc),
    .inc   (wait_inc),
    .tc    (wait_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire && count_q != '1) count_q <= count_q + CNT_W'(1);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ir_write = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED: if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ready) begin
          ir_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wait_tc) begin
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (!SKIP_EN || op_class == CLS_LOAD || op_class == CLS_STORE) state_d = ST_MEMORY;
        else if (op_class == CLS_BRANCH) retire = 1'b1;
        else state_d = ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (bus.dmem_ready) begin
          if (!SKIP_EN || op_class == CLS_LOAD) state_d = ST_WRITEBACK;
          else retire = 1'b1;
        end else if (wait_tc) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITEBACK: retire = 1'b1;
      ST_ERROR: state_d = ST_ERROR;
    endcase
    // halt_req is only looked at on the retiring cycle, and beats start there.
    if (retire) state_d = bus.halt_req ? ST_HALTED : ST_FETCH;
  end

  // ir_write and pc_write qualify the accepting/retiring cycle; the rest are state decodes.
  assign bus.imem_req     = (state_q == ST_FETCH);
  assign bus.ir_write     = ir_write;
  assign bus.reg_read_en  = (state_q == ST_DECODE);
  assign bus.alu_en       = (state_q == ST_EXECUTE);
  assign bus.dmem_req     = (state_q == ST_MEMORY);
  assign bus.reg_write_en = (state_q == ST_WRITEBACK);
  assign bus.pc_write     = retire;
  assign bus.stage        = state_q;
  assign bus.busy         = (state_q >= ST_FETCH) && (state_q <= ST_WRITEBACK);
  assign bus.err          = (state_q == ST_ERROR);
  assign bus.instr_count  = count_q;

endmodule
